// File: rtl/jamma_pkg.sv
// Shared constants for the JAMMA joystick split-bus responder: FSM encodings,
// idle bus value and the bit positions within a player word.
package jamma_pkg;

  localparam logic [2:0] ST_HOLD     = 3'd0;
  localparam logic [2:0] ST_MERGED   = 3'd1;
  localparam logic [2:0] ST_GUARD    = 3'd2;
  localparam logic [2:0] ST_DRIVE_P1 = 3'd3;
  localparam logic [2:0] ST_DRIVE_P2 = 3'd4;

  localparam logic [7:0] JOY_IDLE  = 8'hFF;
  localparam int         JOY_START = 7;
  localparam int         JOY_SPARE = 6;

  // Active-low words: AND keeps a press from either player visible.
  function automatic logic [7:0] joy_merge(input logic [7:0] a, input logic [7:0] b);
    return a & b;
  endfunction

endpackage

// File: rtl/jamma_joy_responder_debounce.sv
// Per-player input conditioner: synchronises the raw active-low word and only
// accepts it once two consecutive sample ticks see the same value.
module joy_debounce
  import jamma_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] raw,
  output logic [7:0] db
);

  localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [7:0]    sync_q [SYNC_STAGES];
  logic [7:0]    synced;
  logic [7:0]    prev;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign synced = sync_q[SYNC_STAGES-1];
  assign tick   = (tick_cnt == TW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= JOY_IDLE;
      tick_cnt <= '0;
      prev     <= JOY_IDLE;
      db       <= JOY_IDLE;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      // Whole-word compare: a partial change restarts the acceptance window.
      if (tick) begin
        prev <= synced;
        if (synced == prev) db <= synced;
      end
    end
  end

endmodule

// File: rtl/jamma_joy_responder.sv
// Adapter-side JAMMA split-bus responder: drives the host-selected player onto
// JJOY with a guard gap, and merges both players when the select stalls.
module jamma_joy_responder
  import jamma_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int GUARD_CYCLES    = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       CLK,
  input  logic       I_RESET_N,
  input  logic       I_JSELECT,
  input  logic [7:0] I_P1,
  input  logic [7:0] I_P2,
  output logic [7:0] O_JJOY,
  output logic       O_JJOY_OE,
  output logic       O_SEL_ALIVE,
  output logic [7:0] O_P1_DB,
  output logic [7:0] O_P2_DB
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sel_sync;
  logic                   s, s_d, sel_edge;
  logic [CW-1:0]          to_cnt, to_next;
  logic                   timeout;
  logic [2:0]             state, state_next;
  logic                   target, target_next;
  logic [GW-1:0]          g_cnt, g_next;
  logic                   guard_done;
  logic [7:0]             jjoy_next;
  logic                   oe_next, alive_next;

  joy_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p1 (
    .clk(CLK), .rst_n(I_RESET_N), .raw(I_P1), .db(O_P1_DB)
  );
  joy_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_p2 (
    .clk(CLK), .rst_n(I_RESET_N), .raw(I_P2), .db(O_P2_DB)
  );

  assign s          = sel_sync[SYNC_STAGES-1];
  assign sel_edge   = s ^ s_d;
  assign to_next    = (to_cnt == CW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + CW'(1);
  assign timeout    = !sel_edge && (to_next == CW'(TIMEOUT_CYCLES));
  assign guard_done = (int'(g_cnt) >= GUARD_CYCLES - 1);

  always_comb begin
    state_next  = state;
    target_next = target;
    g_next      = g_cnt;
    if (state == ST_HOLD) begin
      state_next = ST_MERGED;
    end else if (sel_edge) begin
      // Any select edge (re)starts the guard and latches the new target player.
      target_next = s;
      g_next      = '0;
      if (GUARD_CYCLES == 0) state_next = s ? ST_DRIVE_P2 : ST_DRIVE_P1;
      else                   state_next = ST_GUARD;
    end else if (timeout) begin
      state_next = ST_MERGED;
    end else if (state == ST_GUARD) begin
      if (guard_done) state_next = target ? ST_DRIVE_P2 : ST_DRIVE_P1;
      else            g_next = g_cnt + GW'(1);
    end
  end

  always_comb begin
    jjoy_next  = JOY_IDLE;
    oe_next    = 1'b1;
    alive_next = 1'b0;
    case (state_next)
      ST_HOLD:     oe_next    = 1'b0;
      ST_MERGED:   jjoy_next  = joy_merge(O_P1_DB, O_P2_DB);
      ST_GUARD:    alive_next = 1'b1;
      ST_DRIVE_P1: begin jjoy_next = O_P1_DB; alive_next = 1'b1; end
      ST_DRIVE_P2: begin jjoy_next = O_P2_DB; alive_next = 1'b1; end
      default:     oe_next    = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sel_sync    <= '1;
      s_d         <= 1'b1;
      to_cnt      <= '0;
      state       <= ST_HOLD;
      target      <= 1'b1;
      g_cnt       <= '0;
      O_JJOY      <= JOY_IDLE;
      O_JJOY_OE   <= 1'b0;
      O_SEL_ALIVE <= 1'b0;
    end else begin
      sel_sync    <= {sel_sync[SYNC_STAGES-2:0], I_JSELECT};
      s_d         <= s;
      to_cnt      <= sel_edge ? '0 : to_next;
      state       <= state_next;
      target      <= target_next;
      g_cnt       <= g_next;
      O_JJOY      <= jjoy_next;
      O_JJOY_OE   <= oe_next;
      O_SEL_ALIVE <= alive_next;
    end
  end

endmodule

// File: tb/tb_jamma_joy_responder.sv
// Directed bench for jamma_joy_responder: dut0 uses a 1-cycle guard and short
// timeout, dut1 a 3-cycle guard; both share the same pin stimulus.
module tb_jamma_joy_responder;
  import jamma_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jsel;
  logic [7:0] p1, p2;
  logic [7:0] jjoy0, p1db0, p2db0, jjoy1, p1db1, p2db1;
  logic       oe0, alive0, oe1, alive1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] exp_jjoy;
  } vec_t;
  vec_t vecs[5];

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  jamma_joy_responder #(
    .SYNC_STAGES(2), .GUARD_CYCLES(1), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(32)
  ) dut0 (
    .CLK(clk), .I_RESET_N(rst_n), .I_JSELECT(jsel), .I_P1(p1), .I_P2(p2),
    .O_JJOY(jjoy0), .O_JJOY_OE(oe0), .O_SEL_ALIVE(alive0), .O_P1_DB(p1db0), .O_P2_DB(p2db0)
  );

  jamma_joy_responder #(
    .SYNC_STAGES(2), .GUARD_CYCLES(3), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1024)
  ) dut1 (
    .CLK(clk), .I_RESET_N(rst_n), .I_JSELECT(jsel), .I_P1(p1), .I_P2(p2),
    .O_JJOY(jjoy1), .O_JJOY_OE(oe1), .O_SEL_ALIVE(alive1), .O_P1_DB(p1db1), .O_P2_DB(p2db1)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] cur, nxt, glitch_min;

    vecs[0] = '{8'hFE, 8'hDF, 8'hDE};
    vecs[1] = '{8'h7F, 8'hBF, 8'h3F};
    vecs[2] = '{8'hAA, 8'hFF, 8'hAA};
    vecs[3] = '{8'hC3, 8'h3C, 8'h00};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF};

    // Reset values, then HOLD for one cycle.
    rst_n = 1'b1; jsel = 1'b1; p1 = 8'hFE; p2 = 8'hDF;
    #1 rst_n = 1'b0;
    #2;
    check8("rst_jjoy", jjoy0, 8'hFF);
    check8("rst_oe", {7'd0, oe0}, 8'h00);
    check8("rst_alive", {7'd0, alive0}, 8'h00);
    check8("rst_p1db", p1db0, 8'hFF);
    check8("rst_p2db", p2db0, 8'hFF);
    check8("rst_oe1", {7'd0, oe1}, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    check8("hold_oe", {7'd0, oe0}, 8'h00);
    step(1);
    check8("merged_oe", {7'd0, oe0}, 8'h01);

    // Merged-mode vectors with a static select.
    for (int i = 0; i < 5; i++) begin
      p1 = vecs[i].p1; p2 = vecs[i].p2;
      step(14);
      check8($sformatf("merge%0d_jjoy", i), jjoy0, vecs[i].exp_jjoy);
      check8($sformatf("merge%0d_p1db", i), p1db0, vecs[i].p1);
      check8($sformatf("merge%0d_p2db1", i), p2db1, vecs[i].p2);
      check8($sformatf("merge%0d_alive", i), {7'd0, alive0}, 8'h00);
    end

    // Debounce: 3-cycle glitch is rejected, a held press is accepted.
    p1[0] = 1'b0; step(3); p1[0] = 1'b1;
    glitch_min = 8'hFF;
    for (int i = 0; i < 14; i++) begin step(1); glitch_min &= p1db0; end
    check8("glitch_p1db", glitch_min, 8'hFF);
    p1 = 8'hFE;
    for (int i = 0; i < 11; i++) begin
      step(1);
      if (p1db0 == 8'hFE) break;
    end
    check8("hold_p1db", p1db0, 8'hFE);
    p1[JOY_START] = 1'b0;
    step(14);
    check8("start_p1db", p1db1, 8'h7E);

    // Split drive: toggle select every 8 cycles.
    p1 = 8'hFE; p2 = 8'h7F;
    step(14);
    check8("split_merged", jjoy0, 8'h7E);
    cur = 8'h7E;
    for (int t = 0; t < 6; t++) begin
      jsel = ~jsel;
      nxt = jsel ? 8'h7F : 8'hFE;
      exp_q.push_back(cur); exp_q.push_back(8'hFF); exp_q.push_back(nxt);
      step(2); check8($sformatf("split%0d_old", t), jjoy0, exp_q.pop_front());
      step(1); check8($sformatf("split%0d_gap", t), jjoy0, exp_q.pop_front());
      step(1); check8($sformatf("split%0d_new", t), jjoy0, exp_q.pop_front());
      check8($sformatf("split%0d_alive", t), {7'd0, alive0}, 8'h01);
      step(4); check8($sformatf("split%0d_dut1", t), jjoy1, nxt);
      cur = nxt;
    end

    // Timeout: last edge entered GUARD at posedge 3; MERGED 32 edges later.
    step(26);
    check8("to_before_jjoy", jjoy0, 8'h7F);
    check8("to_before_alive", {7'd0, alive0}, 8'h01);
    step(1);
    check8("to_jjoy", jjoy0, 8'h7E);
    check8("to_alive", {7'd0, alive0}, 8'h00);
    jsel = 1'b0;
    step(3); check8("to_regain_gap", jjoy0, 8'hFF);
    step(1); check8("to_regain_p1", jjoy0, 8'hFE);
    check8("to_regain_alive", {7'd0, alive0}, 8'h01);
    step(10);
    check8("g3_pre", jjoy1, 8'hFE);

    // Guard restart on dut1: a 1-cycle select pulse re-edges inside GUARD.
    jsel = 1'b1; step(1); jsel = 1'b0;
    step(1); check8("g3_old", jjoy1, 8'hFE);
    for (int k = 0; k < 4; k++) begin
      step(1); check8($sformatf("g3_gap%0d", k), jjoy1, 8'hFF);
    end
    check8("g3_alive", {7'd0, alive1}, 8'h01);
    step(1); check8("g3_final", jjoy1, 8'hFE);
    step(1); check8("g3_final_hold", jjoy1, 8'hFE);

    // Asynchronous reset in the middle of DRIVE_P2.
    jsel = 1'b1;
    step(8);
    check8("ar_pre_jjoy", jjoy0, 8'h7F);
    check8("ar_pre_oe", {7'd0, oe0}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check8("ar_jjoy", jjoy0, 8'hFF);
    check8("ar_oe", {7'd0, oe0}, 8'h00);
    check8("ar_alive", {7'd0, alive0}, 8'h00);
    check8("ar_p2db", p2db0, 8'hFF);
    check8("ar_jjoy1", jjoy1, 8'hFF);
    @(posedge clk); #1 rst_n = 1'b1;
    check8("ar_hold_oe", {7'd0, oe0}, 8'h00);
    step(1);
    check8("ar_merged_oe", {7'd0, oe0}, 8'h01);
    check8("ar_merged_jjoy", jjoy0, 8'hFF);
    step(14);
    check8("ar_resettle", jjoy0, 8'h7E);
    check8("ar_resettle_alive", {7'd0, alive0}, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
